// File: rtl/rr_arb_4_pkg.sv
// Shared types and constants for the 4-channel round-robin arbiter stage.
package rr_arb_4_pkg;

  localparam int unsigned N_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  function automatic logic [N_CH-1:0] sel_onehot(sel_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin pick: rotate requests by ptr, take the lowest set bit, rotate back.
module rr_grant_4
  import rr_arb_4_pkg::*;
(
  input  logic [N_CH-1:0] in_valid,
  input  sel_t            ptr,
  output logic            grant_valid,
  output sel_t            g
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  sel_t              idx;

  always_comb begin
    dbl = {in_valid, in_valid} >> ptr;
    rot = dbl[N_CH-1:0];
    idx = '0;
    // Scan downward so the lowest rotated index (closest to ptr) wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) idx = sel_t'(i);
    end
    g           = idx + ptr;
    grant_valid = |in_valid;
  end

endmodule

// File: rtl/rr_arb_4_sel.sv
// Round-robin arbiter over four valid/ready channels feeding a single-entry output register.
// Optional packet lock is compiled in with RR_ARB_4_LOCK_EN.
module rr_arb_4_sel
  import rr_arb_4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_valid,
  output logic [N_CH-1:0]  in_ready,
  input  logic [N_CH-1:0]  in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output sel_t             out_sel,
  output logic             out_last
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  sel_t             out_sel_q;
  logic             out_last_q;
  sel_t             ptr_q;

  logic [N_CH-1:0]  req;
  logic             grant_valid;
  sel_t             g;
  logic             can_load;
  logic             xfer;
  logic             adv;
  logic             win_last;
  logic [WIDTH-1:0] win_data;

`ifdef RR_ARB_4_LOCK_EN
  lock_state_e state_q;
  sel_t        lock_ch_q;

  // While locked, only the owning channel may be considered, even if it is idle.
  assign req      = (state_q == LOCKED) ? (in_valid & sel_onehot(lock_ch_q)) : in_valid;
  assign win_last = in_last[g];
  assign adv      = xfer & in_last[g];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      lock_ch_q <= '0;
    end else if (xfer) begin
      unique case (state_q)
        UNLOCKED: begin
          if (!in_last[g]) begin
            state_q   <= LOCKED;
            lock_ch_q <= g;
          end
        end
        LOCKED: begin
          if (in_last[g]) state_q <= UNLOCKED;
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end
`else
  logic unused_last;

  assign req         = in_valid;
  assign win_last    = 1'b0;
  assign adv         = xfer;
  assign unused_last = ^in_last;
`endif

  rr_grant_4 u_grant (
    .in_valid    (req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .g           (g)
  );

  assign can_load = ~out_valid_q | out_ready;
  assign xfer     = can_load & grant_valid;
  assign in_ready = xfer ? sel_onehot(g) : '0;

  always_comb begin
    win_data = in_data0;
    unique case (g)
      2'd0: win_data = in_data0;
      2'd1: win_data = in_data1;
      2'd2: win_data = in_data2;
      2'd3: win_data = in_data3;
      default: win_data = in_data0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_sel_q   <= g;
        out_last_q  <= win_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (adv) ptr_q <= g + 2'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule
